// File: rtl/intcalc_seq_pkg.sv
// bexkat1Def: shared integer-unit function codes, divider states and decode helpers
package bexkat1Def;

    typedef enum logic [3:0] {
        INT_MUL, INT_MULU, INT_MULX, INT_MULUX,
        INT_DIV, INT_DIVU, INT_MOD, INT_MODU,
        INT_EXT, INT_EXTB, INT_COM, INT_NEG
    } intfunc_t;

    typedef enum logic [1:0] {IDLE, DIV, FIX} divstate_t;

    function automatic logic is_div(input intfunc_t f);
        return f inside {INT_DIV, INT_DIVU, INT_MOD, INT_MODU};
    endfunction

    function automatic logic is_sdiv(input intfunc_t f);
        return f inside {INT_DIV, INT_MOD};
    endfunction

    function automatic logic is_rem(input intfunc_t f);
        return f inside {INT_MOD, INT_MODU};
    endfunction

endpackage

// File: rtl/intcalc_seq_divstep.sv
// intcalc_divstep: one radix-2 restoring-divide iteration (shift, trial subtract, quotient bit)
module intcalc_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] sh, diff;
    // shifted remainder can exceed WIDTH bits, so the trial subtract is one bit wider
    assign sh       = {rem, quo[WIDTH-1]};
    assign diff     = sh - {1'b0, divisor};
    assign rem_next = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/intcalc_seq.sv
// intcalc_seq: bexkat1 execute integer unit, single-cycle ops plus iterative divider.
// Optional BEXKAT1_DIVZERO_TRAP_EN adds divzero_o and a short-cut for divide by zero.
module intcalc_seq import bexkat1Def::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  intfunc_t         func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
`ifdef BEXKAT1_DIVZERO_TRAP_EN
    ,output logic            divzero_o
`endif
);
`ifdef BEXKAT1_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    divstate_t state;
    intfunc_t func_r;
    logic [WIDTH-1:0] cnt, rem, quo, dvs, a_r, rem_step, quo_step, op_res, q_fix, r_fix, div_res;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic neg_q, neg_r, bz, accept, a_neg, b_neg;

    assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign a_neg      = is_sdiv(func_i) && a_i[WIDTH-1];
    assign b_neg      = is_sdiv(func_i) && b_i[WIDTH-1];
    assign prod_s     = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod_u     = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    always_comb begin
        case (func_i)
            INT_MUL:   op_res = prod_s[WIDTH-1:0];
            INT_MULU:  op_res = prod_u[WIDTH-1:0];
            INT_MULX:  op_res = prod_s[2*WIDTH-1:WIDTH];
            INT_MULUX: op_res = prod_u[2*WIDTH-1:WIDTH];
            INT_EXT:   op_res = {{(WIDTH-16){b_i[15]}}, b_i[15:0]};
            INT_EXTB:  op_res = {{(WIDTH-8){b_i[7]}}, b_i[7:0]};
            INT_COM:   op_res = ~b_i;
            INT_NEG:   op_res = -b_i;
            default:   op_res = '0;
        endcase
    end

    intcalc_divstep #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // divide-by-zero values override sign correction
    assign q_fix   = bz ? '1  : neg_q ? -quo : quo;
    assign r_fix   = bz ? a_r : neg_r ? -rem : rem;
    assign div_res = is_rem(func_r) ? r_fix : q_fix;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            func_r      <= INT_MUL;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            a_r         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            bz          <= 1'b0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
`ifdef BEXKAT1_DIVZERO_TRAP_EN
            divzero_o   <= 1'b0;
`endif
        end else if (flush_i) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_o <= 1'b0;
`ifdef BEXKAT1_DIVZERO_TRAP_EN
            divzero_o   <= 1'b0;
`endif
        end else begin
            if (out_ready_i)
                out_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_div(func_i)) begin
                        state  <= (TRAP && b_i == '0) ? FIX : DIV;
                        cnt    <= '0;
                        rem    <= '0;
                        quo    <= a_neg ? -a_i : a_i;
                        dvs    <= b_neg ? -b_i : b_i;
                        a_r    <= a_i;
                        func_r <= func_i;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        bz     <= b_i == '0;
                    end else if (accept) begin
                        result_o    <= op_res;
                        out_valid_o <= 1'b1;
`ifdef BEXKAT1_DIVZERO_TRAP_EN
                        divzero_o   <= 1'b0;
`endif
                    end
                end
                DIV: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + WIDTH'(1);
                    if (cnt == WIDTH'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    result_o    <= div_res;
                    out_valid_o <= 1'b1;
                    cnt         <= '0;
                    state       <= IDLE;
`ifdef BEXKAT1_DIVZERO_TRAP_EN
                    divzero_o   <= bz;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/intcalc_seq.md
Name: intcalc_seq

Overview:
Execute-stage integer unit for bexkat1. Accepts an intfunc_t operation plus operands from decode over a valid/ready handshake and returns a registered result to the writeback stage.
- DIV/MOD/DIVU/MODU run on an iterative radix-2 restoring divider, so no combinational divider sits on the critical path.
- All other intfunc_t operations complete in one cycle.
- Holds in_ready low while busy, which is the pipeline stall source.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 16.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active low
flush_i  input  1  synchronous abort of any in-flight operation
in_valid_i  input  1  operation presented
in_ready_o  output  1  unit can accept an operation this cycle
func_i  input  intfunc_t  operation select
a_i  input  WIDTH  operand 1 (dividend / multiplicand)
b_i  input  WIDTH  operand 2 (divisor / multiplier / ext/com/neg source)
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
result_o  output  WIDTH  result
divzero_o  output  1  divide-by-zero flag, qualified by out_valid_o; BEXKAT1_DIVZERO_TRAP_EN only

Behaviour:
Reset and handshake:
- Reset (rst_i low, asynchronous): state IDLE; in_ready_o=1; out_valid_o=0; result_o=0; divzero_o=0; all datapath registers cleared.
- Accept occurs when in_valid_i && in_ready_o. Operands and func_i are captured on the accept edge.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). The result register may be overwritten in the same cycle it is consumed.

States:
- IDLE: on accept of a non-divide func, compute combinationally and register the result. out_valid_o=1 next cycle (latency 1). State stays IDLE. On accept of a divide func, go to DIV.
- DIV: on entry load the working registers:
  - remainder = 0;
  - quotient = |a| for signed ops, a for unsigned;
  - divisor = |b| for signed ops, b for unsigned.
  Each cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set quo[0] on no-borrow. A WIDTH-bit counter runs WIDTH iterations, then go to FIX.
- FIX: sign correction for signed ops:
  - quotient negated if sign(a)^sign(b);
  - remainder takes sign(a).
  Select quotient (DIV/DIVU) or remainder (MOD/MODU). Register the result, set out_valid_o=1, go to IDLE.
- Divide latency: accept to out_valid_o = WIDTH+2 cycles.

Result hold and flush:
- out_valid_o and result_o hold stable until out_ready_i is sampled high.
- flush_i high: state to IDLE, out_valid_o cleared, counter cleared. Any in-flight or held result is discarded. flush_i takes priority over a simultaneous accept; no accept occurs that cycle.

Single-cycle ops (low WIDTH bits unless stated):
- MUL: signed product; MULU: unsigned product.
- MULX / MULUX: upper WIDTH bits of the 2*WIDTH-bit product.
- EXT: sign-extend b[15:0]; EXTB: sign-extend b[7:0].
- COM: ~b; NEG: -b (two's complement, wraps).
- Undefined func: 0.

Divide boundary cases:
- b==0, any divide: quotient = all ones; remainder = a (signed and unsigned). Forced in FIX, overriding sign correction.
- Signed MIN / -1: quotient = MIN (0x80000000 for WIDTH=32), remainder = 0. No exception.
- |a| < |b|: quotient 0, remainder a.

Optional Feature:
Macro BEXKAT1_DIVZERO_TRAP_EN.
- Defined:
  - divzero_o is present.
  - It is set with out_valid_o when a divide completes with b==0, and cleared on every other result and on flush/reset.
  - Divide by zero skips DIV and goes to FIX next cycle, so latency is 2.
- Undefined: no divzero_o port; divide by zero runs the full WIDTH+2 cycles with the forced values above.

Decomposition:
- intfunc_t (INT_MUL … INT_NEG) and a new divstate_t (IDLE, DIV, FIX) live in package bexkat1Def.
- One natural sub-module: intcalc_divstep, a combinational single-iteration shift/trial-subtract. Inputs rem, quo, divisor; outputs next rem, next quo.
- The rest stays in intcalc_seq.

Test Plan:
- MUL a=0xFFFFFFFE, b=3, out_ready=1 -> result 0xFFFFFFFA one cycle after accept; MULX same -> 0xFFFFFFFF; MULUX same -> 0x00000002.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD after 34 cycles; MOD same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; MODU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and MODU 5/0 -> 5. With BEXKAT1_DIVZERO_TRAP_EN: 2-cycle latency, divzero_o=1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; MOD same -> 0.
- Backpressure: out_ready=0 for 5 cycles after an EXTB b=0x80 result (0xFFFFFF80) -> result held stable, in_ready_o=0; release -> back-to-back COM b=0 accepted same cycle, yields 0xFFFFFFFF.
- Flush at cycle 10 of a DIV -> out_valid_o never asserts, in_ready_o=1 next cycle. Reset asserted mid-DIV -> all outputs 0 immediately, state IDLE.
